// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
//   Bundles the display-side signals of the seven-segment scanner.
//   master : the producer of the display word (drives en/load/data/dp_mask)
//   slave  : the scanner itself (drives anodes/cnodes/digit_sel/frame_done)
//   en         scan enable, 0 freezes the scan
//   load       capture data into the pending register this cycle
//   data       word to display, nibble i -> digit i (digit 0 rightmost)
//   dp_mask    decimal point enable per digit, 1 = lit
//   anodes     digit enables, active-low
//   cnodes     segments a..g on bits 0..6, dp on bit 7, active-low
//   digit_sel  index of the digit currently on anodes
//   frame_done one-cycle pulse at each completed 8-digit frame
interface seg_scan_display_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  en;
    logic                  load;
    logic [DATA_WIDTH-1:0] data;
    logic [7:0]            dp_mask;
    logic [7:0]            anodes;
    logic [7:0]            cnodes;
    logic [2:0]            digit_sel;
    logic                  frame_done;

    modport master (
        output en, load, data, dp_mask,
        input  anodes, cnodes, digit_sel, frame_done
    );

    modport slave (
        input  en, load, data, dp_mask,
        output anodes, cnodes, digit_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed 8-digit hex seven-segment driver. A word loaded into
//   the pending register is copied to the shadow register only at a frame
//   boundary, so each refresh frame shows digits from one word only.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   seg_scan_display_if.slave (en, load, data, dp_mask in;
//         anodes, cnodes, digit_sel, frame_done out)
module seg_scan_display #(
    parameter int DATA_WIDTH    = 32,
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_display_if.slave   bus
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("seg_scan_display: DATA_WIDTH must be 32 (8 hex digits)");
    end

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = (SCAN_DIV > 1) ? DIV_W'(SCAN_DIV - 1) : '0;

    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            idx;
    logic [DATA_WIDTH-1:0] pending;
    logic [DATA_WIDTH-1:0] shadow;
    logic                  tick;
    logic                  boundary;
    logic [DATA_WIDTH-1:0] upper;
    logic [6:0]            seg_next;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_seg = 7'h40;
            4'h1:    hex_seg = 7'h79;
            4'h2:    hex_seg = 7'h24;
            4'h3:    hex_seg = 7'h30;
            4'h4:    hex_seg = 7'h19;
            4'h5:    hex_seg = 7'h12;
            4'h6:    hex_seg = 7'h02;
            4'h7:    hex_seg = 7'h78;
            4'h8:    hex_seg = 7'h00;
            4'h9:    hex_seg = 7'h10;
            4'hA:    hex_seg = 7'h08;
            4'hB:    hex_seg = 7'h03;
            4'hC:    hex_seg = 7'h46;
            4'hD:    hex_seg = 7'h21;
            4'hE:    hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    // With a divide of 0 or 1 every enabled clock advances the scan.
    assign tick     = (SCAN_DIV <= 1) ? bus.en : (bus.en && (div_cnt == DIV_LAST));
    assign boundary = tick && (idx == 3'd7);

    // Digits above the current one, shifted down; all-zero means this digit
    // is a leading zero and can be blanked.
    always_comb begin
        upper    = shadow >> {idx, 2'b00};
        seg_next = hex_seg(upper[3:0]);
        if ((BLANK_LEADING != 0) && (idx != 3'd0) && (upper == '0)) begin
            seg_next = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt        <= '0;
            idx            <= 3'd0;
            pending        <= '0;
            shadow         <= '0;
            bus.anodes     <= 8'hFF;
            bus.cnodes     <= 8'hFF;
            bus.digit_sel  <= 3'd0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= boundary;

            if (bus.load) begin
                pending <= bus.data;
            end
            // A load on the boundary cycle bypasses pending straight into shadow.
            if (boundary) begin
                shadow <= bus.load ? bus.data : pending;
            end

            if (bus.en) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    idx <= idx + 3'd1;
                end
                bus.digit_sel <= idx;
                bus.anodes    <= ~(8'b1 << idx);
                bus.cnodes    <= {~bus.dp_mask[idx], seg_next};
            end
        end
    end

endmodule
